// File: rtl/data_mem_responder.sv
// Data memory for a processor MEM stage with a byte-serial preload front end.
// LOAD fills the array from a byte stream while busy holds the processor in reset; RUN serves loads and masked stores.
module data_mem_responder #(
  parameter int DEPTH = 512
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic [63:0] wdata,
  input  logic [7:0]  wmask,
  output logic [63:0] rdata,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        busy,
  output logic        err,
  output logic [31:0] wr_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 3;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] ptr;
  logic [63:0]   mem [DEPTH];

  logic [28:0]   word_idx;
  logic          in_range;
  logic          load_fire;
  logic          store_fire;
  logic          bad_access;

  logic [7:0]    we_lanes;
  logic [AW-1:0] w_idx;
  logic [63:0]   w_data;

  assign word_idx   = addr[31:3];
  assign in_range   = word_idx < 29'(DEPTH);
  assign load_fire  = (state == LOAD) && ld_valid;
  assign store_fire = (state == RUN) && wr_en && in_range;
  // Address zero is the processor's idle bus value, so only a nonzero stray read is an error.
  assign bad_access = (state == RUN) && !in_range && (wr_en || (addr != '0));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= LOAD;
    end else begin
      // NOTE: every register in an always_ff takes <= so all flops sample pre-edge values together.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: defaulting every always_comb output first keeps partial branches from inferring latches.
    state_next = state;
    if (load_fire && (ld_last || (ptr == '1))) begin
      state_next = RUN;
    end
  end

  always_comb begin
    ld_ready = (state == LOAD);
    busy     = (state == LOAD);
    rdata    = '0;
    if ((state == RUN) && in_range) begin
      rdata = mem[word_idx[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr      <= '0;
      wr_count <= '0;
      err      <= 1'b0;
    end else begin
      if (load_fire) begin
        ptr <= ptr + 1'b1;
      end
      if (store_fire) begin
        wr_count <= wr_count + 32'd1;
      end
      if (bad_access) begin
        err <= 1'b1;
      end
    end
  end

  // Preload and processor stores share one write port; the state decides which owns it.
  always_comb begin
    we_lanes = '0;
    w_idx    = word_idx[AW-1:0];
    w_data   = wdata;
    if (load_fire) begin
      we_lanes = 8'(1) << ptr[2:0];
      w_idx    = ptr[PW-1:3];
      w_data   = {8{ld_byte}};
    end else if (store_fire) begin
      we_lanes = wmask;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; contents survive nrst by design.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we_lanes[i]) begin
        mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: expectations go into a scoreboard queue
// when stimulus is driven and are popped when the matching DUT output is sampled.
module tb_data_mem_responder;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] addr = '0;
  logic        wr_en = 1'b0;
  logic [63:0] wdata = '0;
  logic [7:0]  wmask = '0;
  logic [63:0] rdata;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        busy;
  logic        err;
  logic [31:0] wr_count;

  data_mem_responder #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .addr     (addr),
    .wr_en    (wr_en),
    .wdata    (wdata),
    .wmask    (wmask),
    .rdata    (rdata),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .busy     (busy),
    .err      (err),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] value;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push_exp(input string tag, input logic [63:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [63:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required no output", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.value) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] value);
    push_exp(tag, value);
    observe(obs);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    addr  = a;
    wdata = d;
    wmask = m;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_word(input logic [31:0] a, output logic [63:0] d);
    addr  = a;
    wr_en = 1'b0;
    #1;
    d = rdata;
  endtask

  // Stream pattern; bytes 16..31 are zero so words 2 and 3 start from a known zero.
  function automatic logic [7:0] stream_byte(input int i);
    if (i >= 16 && i < 32) return 8'h00;
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [63:0] stream_word(input int w);
    logic [63:0] r;
    for (int l = 0; l < 8; l++) r[8*l +: 8] = stream_byte(8 * w + l);
    return r;
  endfunction

  initial begin
    logic [63:0] d;

    // Reset state
    #2;
    check("rst_busy",     {63'b0, busy},     64'd1);
    check("rst_ld_ready", {63'b0, ld_ready}, 64'd1);
    check("rst_rdata",    rdata,             64'd0);
    check("rst_wr_count", {32'b0, wr_count}, 64'd0);
    check("rst_err",      {63'b0, err},      64'd0);
    tick();
    nrst = 1'b1;

    // Full stream without ld_last: RUN entered on the final byte through pointer wrap
    for (int i = 0; i < DEPTH * 8 - 1; i++) send_byte(stream_byte(i), 1'b0);
    check("stream_busy_before_last", {63'b0, busy}, 64'd1);
    send_byte(stream_byte(DEPTH * 8 - 1), 1'b0);
    check("stream_busy_after_last",     {63'b0, busy},     64'd0);
    check("stream_ld_ready_after_last", {63'b0, ld_ready}, 64'd0);
    ld_valid = 1'b1;
    ld_byte  = 8'hEE;
    #1;
    check("run_extra_ld_ready", {63'b0, ld_ready}, 64'd0);
    tick();
    ld_valid = 1'b0;
    read_word(32'h0, d);
    check("stream_word0", d, stream_word(0));
    read_word(32'((DEPTH - 1) * 8), d);
    check("stream_word_last", d, stream_word(DEPTH - 1));
    read_word(32'h10, d);
    check("stream_word2_zero", d, 64'd0);

    // Short preload with ld_last on byte 16
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
    for (int i = 1; i < 16; i++) send_byte(8'(i), 1'b0);
    check("pre_busy_before_last", {63'b0, busy}, 64'd1);
    send_byte(8'h10, 1'b1);
    check("pre_busy_after_last", {63'b0, busy}, 64'd0);
    read_word(32'h0, d);
    check("pre_word0", d, 64'h0807060504030201);
    read_word(32'h8, d);
    check("pre_word1", d, 64'h100F0E0D0C0B0A09);
    read_word(32'h3, d);
    check("pre_low_addr_bits_ignored", d, 64'h0807060504030201);

    // Masked store over zero contents
    push_exp("store_mask_0f", 64'h00000000EEFF0011);
    store(32'h10, 64'hAABBCCDDEEFF0011, 8'h0F);
    read_word(32'h10, d);
    observe(d);
    check("store_count_1", {32'b0, wr_count}, 64'd1);

    // Same-cycle store and read: old data now, new data after the edge
    addr  = 32'h18;
    wdata = 64'h1122334455667788;
    wmask = 8'hFF;
    wr_en = 1'b1;
    push_exp("same_cycle_old", 64'd0);
    push_exp("same_cycle_new", 64'h1122334455667788);
    #1;
    observe(rdata);
    tick();
    wr_en = 1'b0;
    #1;
    observe(rdata);
    check("store_count_2", {32'b0, wr_count}, 64'd2);

    // wmask=0 writes nothing but still counts
    store(32'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    read_word(32'h10, d);
    check("mask_zero_no_write", d, 64'h00000000EEFF0011);
    check("mask_zero_counts",   {32'b0, wr_count}, 64'd3);
    check("no_err_in_range",    {63'b0, err},      64'd0);

    // Out-of-range store: dropped, sticky err, count held, rdata zero
    addr  = 32'h1000;
    wdata = 64'hDEADBEEFCAFEF00D;
    wmask = 8'hFF;
    wr_en = 1'b1;
    #1;
    check("oor_rdata_zero", rdata, 64'd0);
    tick();
    wr_en = 1'b0;
    check("oor_err_set",     {63'b0, err},      64'd1);
    check("oor_count_held",  {32'b0, wr_count}, 64'd3);
    read_word(32'h0, d);
    check("oor_no_alias_word0", d, 64'h0807060504030201);
    tick();
    tick();
    check("oor_err_sticky", {63'b0, err}, 64'd1);

    // Asynchronous reset from RUN, between clock edges
    #2;
    nrst = 1'b0;
    #1;
    check("async_rst_busy",     {63'b0, busy},     64'd1);
    check("async_rst_ld_ready", {63'b0, ld_ready}, 64'd1);
    check("async_rst_count",    {32'b0, wr_count}, 64'd0);
    check("async_rst_err",      {63'b0, err},      64'd0);
    check("async_rst_rdata",    rdata,             64'd0);
    tick();
    nrst = 1'b1;

    // Reset mid-preload restarts the pointer at byte 0
    for (int i = 1; i <= 5; i++) send_byte(8'(8'hA0 + i), 1'b0);
    nrst = 1'b0;
    #1;
    check("mid_pre_rst_busy", {63'b0, busy}, 64'd1);
    nrst = 1'b1;
    send_byte(8'h77, 1'b1);
    check("mid_pre_busy_low", {63'b0, busy}, 64'd0);
    read_word(32'h0, d);
    check("mid_pre_restart_byte0", d, 64'h080706A5A4A3A277);

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d entries left required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 512, number of 64-bit words (power of two, 2..65536) SHALL be supported.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port nrst  input  1  reset; asynchronous, active-low.
REQ-004 Port addr  input  32  byte address from the processor MEM stage.
REQ-005 Port wr_en  input  1  processor store request.
REQ-006 Port wdata  input  64  store data.
REQ-007 Port wmask  input  8  byte-lane enables; bit i covers wdata[8i+7:8i].
REQ-008 Port rdata  output  64  load data to the processor.
REQ-009 Port ld_valid  input  1  preload byte valid.
REQ-010 Port ld_byte  input  8  preload byte.
REQ-011 Port ld_last  input  1  marks the final preload byte.
REQ-012 Port ld_ready  output  1  preload byte accepted when ld_valid & ld_ready.
REQ-013 Port busy  output  1  high while preloading; the processor is held in reset while busy.
REQ-014 Port err  output  1  sticky out-of-range access flag.
REQ-015 Port wr_count  output  32  count of committed processor stores.

Function
REQ-016 Word index SHALL be addr[31:3]; addr[2:0] is ignored, and lanes are selected only by wmask.
REQ-017 An access is in range iff addr[31:3] < DEPTH.
REQ-018 The FSM SHALL have two states: LOAD (entered on reset) and RUN.
REQ-019 In LOAD: ld_ready=1, busy=1, rdata=0, and processor wr_en SHALL be ignored (no write, no count, no err).
REQ-020 In LOAD, each handshake SHALL write ld_byte to word (ptr>>3), lane (ptr&7), then increment ptr; ptr is an internal byte pointer, width log2(DEPTH)+3.
REQ-021 LOAD->RUN SHALL occur on the edge that accepts a byte with ld_last=1, or that accepts byte DEPTH*8-1 (pointer wrap); no further bytes are written.
REQ-022 In RUN: ld_ready=0, busy=0; ld_valid SHALL be ignored; RUN is left only by reset.
REQ-023 In RUN, rdata SHALL be combinational: mem[addr[31:3]] when in range, else 0 (zero-latency, sampled by the processor MEM/WB register).
REQ-024 In RUN, when wr_en=1 and in range, each byte lane with wmask[i]=1 SHALL be written at the clock edge; unmasked lanes keep their value; wmask=0 writes nothing, but the store still counts.
REQ-025 A read in the same cycle as a write to the same word SHALL return pre-write data; new data is visible the following cycle.
REQ-026 wr_count SHALL increment by 1 per RUN cycle with wr_en=1 and in range; it wraps 0xFFFFFFFF->0.
REQ-027 err SHALL set on any RUN cycle with wr_en=1 out of range, or with an out-of-range addr whose read result is consumed (wr_en=0 and addr nonzero out of range); the write is dropped, and err stays set until reset.
REQ-028 Simultaneous ld_valid and wr_en SHALL be handled by state alone (LOAD honours only the preload, RUN honours only the processor).

Reset
REQ-029 On nrst=0 (asynchronous): state=LOAD, ptr=0, wr_count=0, err=0, ld_ready=1, busy=1, rdata=0.
REQ-030 Memory array contents SHALL NOT be reset; reset mid-preload restarts at ptr=0 and overwrites from byte 0.
REQ-031 Outputs SHALL take their reset values within the same cycle nrst falls, independent of clk.

Verification
REQ-032 Preload bytes 0x01..0x10 with ld_last on byte 16 -> busy falls after the 16th handshake; addr=0 gives rdata=0x0807060504030201, and addr=8 gives 0x100F0E0D0C0B0A09.
REQ-033 RUN: store addr=0x10, wdata=0xAABBCCDDEEFF0011, wmask=0x0F, over prior contents 0 -> next cycle rdata=0x00000000EEFF0011; wr_count=1.
REQ-034 Same-cycle store and read of addr=0x18 -> rdata shows old value in that cycle and new value the next cycle.
REQ-035 DEPTH=512, store to addr=0x1000 -> no array change, err=1 and held, wr_count unchanged, rdata=0.
REQ-036 Assert nrst low after 5 preload bytes -> immediate busy=1, wr_count=0, err=0; the next preload byte lands at byte 0.
REQ-037 Stream DEPTH*8 bytes without ld_last -> RUN is entered on the final byte; the extra ld_valid is ignored and ld_ready=0.
